// File: rtl/seq_subtractor32_4_if.sv
// Operand/result stream bundle for seq_subtractor32_4.
// The master side supplies operands and consumes results; the slave side is the subtractor.
interface seq_subtractor32_4_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH:0]   diff;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output a, b, in_valid, out_ready,
    input  in_ready, diff, out_valid
  );

  modport slave (
    input  a, b, in_valid, out_ready,
    output in_ready, diff, out_valid
  );
endinterface

// File: rtl/seq_subtractor32_4.sv
// Multi-cycle unsigned subtractor: computes a - b one BLOCK-bit slice per clock,
// rippling the borrow through a register. Bit WIDTH of diff is the final borrow.
module seq_subtractor32_4 #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 4
) (
  input logic                 clk,
  input logic                 rst,
  seq_subtractor32_4_if.slave bus
);
  localparam int NB = WIDTH / BLOCK;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ra, rb;
  logic [WIDTH:0]   diff_q;
  logic [IW-1:0]    idx;
  logic             bw;
  logic [BLOCK:0]   t;
  logic             accept;
  logic             last;

  assign accept = bus.in_valid && (state_q == IDLE);
  assign last   = (idx == IW'(NB - 1));

  // One slice of the subtraction; t[BLOCK] is the borrow out of this block.
  always_comb begin
    t = {1'b0, ra[idx*BLOCK +: BLOCK]} - {1'b0, rb[idx*BLOCK +: BLOCK]} - {{BLOCK{1'b0}}, bw};
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: a default assignment before the case keeps this combinational block
  // latch-free even when a branch does not assign state_d.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid) state_d = RUN;
      RUN:     if (last)         state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
  end

  // NOTE: ra/rb are pure operand storage, loaded on every accept before use,
  // so they carry no reset; only control state and the visible result do.
  always_ff @(posedge clk) begin
    if (accept) begin
      ra <= bus.a;
      rb <= bus.b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      diff_q <= '0;
      bw     <= 1'b0;
      idx    <= '0;
    end else if (accept) begin
      diff_q <= '0;
      bw     <= 1'b0;
      idx    <= '0;
    end else if (state_q == RUN) begin
      diff_q[idx*BLOCK +: BLOCK] <= t[BLOCK-1:0];
      bw                         <= t[BLOCK];
      if (last) diff_q[WIDTH] <= t[BLOCK];
      else      idx           <= idx + IW'(1);
    end
  end

  assign bus.diff = diff_q;
endmodule
